// File: rtl/serial_frame_tx.sv
// Framed serial transmitter: start bit, WIDTH data bits LSB first, optional even parity, stop bit.
// Every output is a flop; values are precomputed from the next state so sout changes on the bit boundary.
module serial_frame_tx #(
  parameter int WIDTH      = 8,
  parameter int BIT_CYCLES = 4,
  parameter int PARITY_EN  = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             load,
  output logic             ready,
  output logic             sout,
  output logic             busy,
  output logic             done
);

  localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CYC_LAST = CW'(BIT_CYCLES - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] shreg, shreg_nxt;
  logic [BW-1:0]    bit_cnt, bit_nxt;
  logic [CW-1:0]    cyc_cnt, cyc_nxt;
  logic             par_bit, par_nxt;
  logic             sout_nxt;
  logic             done_nxt;
  logic             bit_end;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
      cyc_cnt <= '0;
      par_bit <= 1'b0;
      sout    <= 1'b1;
      ready   <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_nxt;
      shreg   <= shreg_nxt;
      bit_cnt <= bit_nxt;
      cyc_cnt <= cyc_nxt;
      par_bit <= par_nxt;
      sout    <= sout_nxt;
      ready   <= (state_nxt == IDLE);
      busy    <= (state_nxt != IDLE);
      done    <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    shreg_nxt = shreg;
    bit_nxt   = bit_cnt;
    cyc_nxt   = cyc_cnt;
    par_nxt   = par_bit;
    done_nxt  = 1'b0;
    sout_nxt  = 1'b1;
    bit_end   = (cyc_cnt == CYC_LAST);

    case (state)
      IDLE: begin
        if (load) begin
          shreg_nxt = din;
          par_nxt   = ^din;
          bit_nxt   = '0;
          cyc_nxt   = '0;
          state_nxt = START;
        end
      end
      START: begin
        if (bit_end) begin
          cyc_nxt   = '0;
          bit_nxt   = '0;
          state_nxt = DATA;
        end else begin
          cyc_nxt = cyc_cnt + 1'b1;
        end
      end
      DATA: begin
        if (bit_end) begin
          cyc_nxt   = '0;
          shreg_nxt = shreg >> 1;
          if (bit_cnt == BIT_LAST) begin
            bit_nxt   = '0;
            state_nxt = (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            bit_nxt = bit_cnt + 1'b1;
          end
        end else begin
          cyc_nxt = cyc_cnt + 1'b1;
        end
      end
      PARITY: begin
        if (bit_end) begin
          cyc_nxt   = '0;
          state_nxt = STOP;
        end else begin
          cyc_nxt = cyc_cnt + 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          cyc_nxt   = '0;
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end else begin
          cyc_nxt = cyc_cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    // Line level for the upcoming cycle; in DATA the shifted word already holds the next bit in [0].
    case (state_nxt)
      START:   sout_nxt = 1'b0;
      DATA:    sout_nxt = shreg_nxt[0];
      PARITY:  sout_nxt = par_nxt;
      default: sout_nxt = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_serial_frame_tx.sv
// Directed bench for serial_frame_tx: one instance without parity, one with even parity.
module tb_serial_frame_tx;

  logic       clk;
  logic       clkRun;
  logic       rst;
  logic [7:0] din;
  logic       load0, load1;
  logic       ready0, sout0, busy0, done0;
  logic       ready1, sout1, busy1, done1;

  int checkCount;
  int passCount;

  serial_frame_tx #(.WIDTH(8), .BIT_CYCLES(4), .PARITY_EN(0)) dut0 (
    .clk(clk), .rst(rst), .din(din), .load(load0),
    .ready(ready0), .sout(sout0), .busy(busy0), .done(done0)
  );

  serial_frame_tx #(.WIDTH(8), .BIT_CYCLES(4), .PARITY_EN(1)) dut1 (
    .clk(clk), .rst(rst), .din(din), .load(load1),
    .ready(ready1), .sout(sout1), .busy(busy1), .done(done1)
  );

  initial clk = 1'b0;
  always #5 if (clkRun) clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected)
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    else
      passCount++;
  endtask

  task automatic applyStimulus(input bit sel, input bit v);
    if (sel) load1 = v;
    else     load0 = v;
  endtask

  // Launches a word and checks every line cycle against the hand-written frame, then the done cycle.
  task automatic sendFrame(input bit sel, input logic [7:0] word, input logic [15:0] bits,
                           input int nbits, input bit hold, input int injectAt);
    int len;
    len = nbits * 4;
    din = word;
    applyStimulus(sel, 1'b1);
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      if (i == 0 && !hold) applyStimulus(sel, 1'b0);
      if (i == injectAt) begin
        din = 8'hFF;
        applyStimulus(sel, 1'b1);
      end
      if (i == injectAt + 1) applyStimulus(sel, 1'b0);
      checkOutput($sformatf("sout[%0d]", i), sel ? sout1 : sout0, bits[i/4]);
      if (i % 4 == 0) begin
        checkOutput($sformatf("busy[%0d]", i), sel ? busy1 : busy0, 1);
        checkOutput($sformatf("done[%0d]", i), sel ? done1 : done0, 0);
        checkOutput($sformatf("ready[%0d]", i), sel ? ready1 : ready0, 0);
      end
    end
    @(negedge clk);
    checkOutput("doneEnd", sel ? done1 : done0, 1);
    checkOutput("readyEnd", sel ? ready1 : ready0, 1);
    checkOutput("busyEnd", sel ? busy1 : busy0, 0);
    checkOutput("soutEnd", sel ? sout1 : sout0, 1);
  endtask

  task automatic checkIdle(input bit sel, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      checkOutput("idleSout", sel ? sout1 : sout0, 1);
      checkOutput("idleBusy", sel ? busy1 : busy0, 0);
      checkOutput("idleDone", sel ? done1 : done0, 0);
    end
  endtask

  initial begin
    checkCount = 0;
    passCount  = 0;
    clkRun = 1'b0;
    rst    = 1'b0;
    load0  = 1'b0;
    load1  = 1'b0;
    din    = 8'h00;

    // Asynchronous reset with the clock stopped.
    #3 rst = 1'b1;
    #1;
    checkOutput("rstSout0", sout0, 1);
    checkOutput("rstReady0", ready0, 1);
    checkOutput("rstBusy0", busy0, 0);
    checkOutput("rstDone0", done0, 0);
    checkOutput("rstSout1", sout1, 1);
    checkOutput("rstReady1", ready1, 1);
    #2 clkRun = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checkIdle(0, 2);

    $display("[TB] basic frame A5");
    sendFrame(0, 8'hA5, 16'b1_10100101_0, 10, 0, -1);
    checkIdle(0, 2);

    $display("[TB] parity frames 07 and A5");
    sendFrame(1, 8'h07, 16'b1_1_00000111_0, 11, 0, -1);
    checkIdle(1, 2);
    sendFrame(1, 8'hA5, 16'b1_0_10100101_0, 11, 0, -1);
    checkIdle(1, 2);

    $display("[TB] ignored load during 3C");
    sendFrame(0, 8'h3C, 16'b1_00111100_0, 10, 0, 10);
    checkIdle(0, 8);

    $display("[TB] back-to-back 01 then 80");
    sendFrame(0, 8'h01, 16'b1_00000001_0, 10, 1, -1);
    sendFrame(0, 8'h80, 16'b1_10000000_0, 10, 0, -1);
    checkIdle(0, 3);

    $display("[TB] reset during data bit 3");
    din = 8'hA5;
    applyStimulus(0, 1'b1);
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      if (i == 0) applyStimulus(0, 1'b0);
    end
    checkOutput("preAbortSout", sout0, 0);
    checkOutput("preAbortBusy", busy0, 1);
    #2 rst = 1'b1;
    #1;
    checkOutput("abortSout", sout0, 1);
    checkOutput("abortBusy", busy0, 0);
    checkOutput("abortReady", ready0, 1);
    checkOutput("abortDone", done0, 0);
    @(negedge clk);
    rst = 1'b0;
    checkIdle(0, 30);
    sendFrame(0, 8'hA5, 16'b1_10100101_0, 10, 0, -1);
    checkIdle(0, 2);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
